// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache arbiter: FSM states, memory operation kind and
// requester identity.
package arbiter_types;

    typedef enum logic [2:0] {
        IDLE,
        GNT_I,
        GNT_D,
        RSP_I,
        RSP_D
    } arb_state_t;

    typedef enum logic {
        READ,
        WRITE
    } arb_op_t;

    typedef enum logic {
        SRC_I,
        SRC_D
    } arb_src_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of the icache, dcache and memory-adaptor line ports around the
// cache arbiter.
//   slave  : arbiter view (cache requests in, memory ops out)
//   master : environment view (caches + adaptor)
// Signals:
//   i_read/i_addr -> i_rdata/i_resp              icache miss path
//   d_read/d_write/d_addr/d_wdata -> d_rdata/d_resp  dcache miss/writeback
//   mem_read/mem_write/mem_addr/mem_wdata <- mem_rdata/mem_resp  adaptor
interface cache_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  i_read, i_addr,
        output i_rdata, i_resp,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_resp,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output i_read, i_addr,
        input  i_rdata, i_resp,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_resp,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/cache_arbiter.sv
// Cache arbiter: serialises icache and dcache line transactions onto the
// single memory-adaptor port, one at a time, with round-robin fairness.
// All memory-side and cache-side outputs come straight from registers.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : cache_arbiter_if.slave (icache, dcache and adaptor line ports)
module cache_arbiter
    import arbiter_types::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    cache_arbiter_if.slave  bus
);

    arb_state_t        state_q, state_d;
    arb_src_t          last_q, last_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              i_resp_q, i_resp_d;
    logic              d_resp_q, d_resp_d;

    logic              i_pend;
    logic              d_pend;
    arb_src_t          src;
    arb_op_t           op;

    assign i_pend = bus.i_read;
    assign d_pend = bus.d_read | bus.d_write;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        line_d   = line_q;
        i_resp_d = 1'b0;
        d_resp_d = 1'b0;
        src      = SRC_I;
        op       = READ;

        case (state_q)
            IDLE: begin
                if (i_pend || d_pend) begin
                    // On a tie the requester that did not win last time goes.
                    if (i_pend && d_pend)
                        src = (last_q == SRC_I) ? SRC_D : SRC_I;
                    else
                        src = i_pend ? SRC_I : SRC_D;
                    last_d = src;
                    if (src == SRC_I) begin
                        addr_d  = bus.i_addr;
                        op      = READ;
                        state_d = GNT_I;
                    end else begin
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                        // A simultaneous read+write is resolved as a write.
                        op      = bus.d_write ? WRITE : READ;
                        state_d = GNT_D;
                    end
                    rd_d = (op == READ);
                    wr_d = (op == WRITE);
                end
            end
            GNT_I, GNT_D: begin
                if (bus.mem_resp) begin
                    line_d   = bus.mem_rdata;
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    i_resp_d = (state_q == GNT_I);
                    d_resp_d = (state_q == GNT_D);
                    state_d  = (state_q == GNT_I) ? RSP_I : RSP_D;
                end
            end
            RSP_I, RSP_D: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_q   <= SRC_I;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            line_q   <= '0;
            i_resp_q <= 1'b0;
            d_resp_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            line_q   <= line_d;
            i_resp_q <= i_resp_d;
            d_resp_q <= d_resp_d;
        end
    end

    assign bus.mem_read  = rd_q;
    assign bus.mem_write = wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_rdata   = line_q;
    assign bus.d_rdata   = line_q;
    assign bus.i_resp    = i_resp_q;
    assign bus.d_resp    = d_resp_q;

    // The dcache must never present read and write together.
    a_d_rw_excl: assert property (@(posedge clk) disable iff (!rst)
        (state_q == IDLE) |-> !(bus.d_read && bus.d_write))
        else $warning("cache_arbiter: d_read and d_write both high, issuing write");

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] wdata;
        bit           rd;
        bit           wr;
        int           cyc;
    } gnt_t;

    typedef struct {
        bit           is_d;
        logic [255:0] data;
        int           cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

    cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 4;
    bit spurious = 1'b0;
    int wide_cnt = 0;

    gnt_t gq[$];
    rsp_t rq[$];
    int   blen[$];

    logic [255:0] ref_mem [logic [31:0]];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] pattern(input logic [31:0] a);
        return {a, ~a, a ^ 32'h0F0F_0F0F, a ^ 32'hF0F0_F0F0,
                a ^ 32'h1234_5678, a ^ 32'h8765_4321,
                {a[15:0], a[31:16]}, ~{a[15:0], a[31:16]}};
    endfunction

    function automatic logic [255:0] rnd_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_l(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory adaptor: answers after `lat` cycles of a held request, backed by
    // its own line store.
    initial begin : adaptor
        int acnt;
        logic [255:0] amem [logic [31:0]];
        acnt = 0;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_read || bus.mem_write) acnt = acnt + 1;
            else acnt = 0;
            bus.mem_resp = spurious || (acnt == lat);
            if (acnt == lat) begin
                if (bus.mem_write) amem[bus.mem_addr] = bus.mem_wdata;
                bus.mem_rdata = amem.exists(bus.mem_addr) ? amem[bus.mem_addr]
                                                          : pattern(bus.mem_addr);
            end else begin
                bus.mem_rdata = rnd_line();
            end
        end
    end

    // Passive monitor: logs grants, busy lengths and response pulses.
    initial begin : monitor
        bit pb, pi, pd, busy;
        int len;
        pb = 0; pi = 0; pd = 0; len = 0;
        forever begin
            @(negedge clk);
            busy = bus.mem_read || bus.mem_write;
            if (busy && !pb) begin
                gq.push_back('{addr: bus.mem_addr, wdata: bus.mem_wdata,
                               rd: bus.mem_read, wr: bus.mem_write, cyc: cyc});
                len = 0;
            end
            if (busy) len++;
            if (!busy && pb) blen.push_back(len);
            if (bus.i_resp === 1'b1) begin
                rq.push_back('{is_d: 1'b0, data: bus.i_rdata, cyc: cyc});
                if (pi) wide_cnt++;
            end
            if (bus.d_resp === 1'b1) begin
                rq.push_back('{is_d: 1'b1, data: bus.d_rdata, cyc: cyc});
                if (pd) wide_cnt++;
            end
            if (bus.i_resp === 1'b1 && bus.d_resp === 1'b1) wide_cnt++;
            pb = busy;
            pi = (bus.i_resp === 1'b1);
            pd = (bus.d_resp === 1'b1);
        end
    end

    // Cache-side request: raised at a negedge, held until the resp pulse.
    task automatic i_txn(input logic [31:0] a, output logic [255:0] data, output int rcyc);
        bus.i_addr = a;
        bus.i_read = 1'b1;
        rcyc = -1;
        data = '0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.i_resp === 1'b1) begin
                data = bus.i_rdata;
                rcyc = cyc;
                break;
            end
        end
        bus.i_read = 1'b0;
    endtask

    task automatic d_txn(input logic [31:0] a, input bit rd, input bit wr,
                         input logic [255:0] wd, output logic [255:0] data, output int rcyc);
        bus.d_addr  = a;
        bus.d_wdata = wd;
        bus.d_read  = rd;
        bus.d_write = wr;
        rcyc = -1;
        data = '0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.d_resp === 1'b1) begin
                data = bus.d_rdata;
                rcyc = cyc;
                break;
            end
        end
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [255:0] dd, di, wd;
        int rc, ri, rd, c0, gb, rb, bb;

        bus.i_read = 0; bus.i_addr = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk_i("rst_mem_read", int'(bus.mem_read), 0);
        chk_i("rst_mem_write", int'(bus.mem_write), 0);
        chk_i("rst_i_resp", int'(bus.i_resp), 0);
        chk_i("rst_d_resp", int'(bus.d_resp), 0);
        chk_i("rst_mem_addr", int'(bus.mem_addr), 0);
        chk_l("rst_mem_wdata", bus.mem_wdata, '0);
        chk_l("rst_i_rdata", bus.i_rdata, '0);
        chk_l("rst_d_rdata", bus.d_rdata, '0);
        rst = 1'b1;
        @(negedge clk);

        // icache read, latency 4
        lat = 4; gb = gq.size(); rb = rq.size(); bb = blen.size(); c0 = cyc;
        i_txn(32'h0000_0040, di, rc);
        repeat (2) @(negedge clk);
        chk_i("t1_grants", gq.size() - gb, 1);
        chk_i("t1_grant_cyc", gq[gb].cyc, c0 + 1);
        chk_i("t1_mem_addr", int'(gq[gb].addr), 32'h40);
        chk_i("t1_is_read", int'({gq[gb].rd, gq[gb].wr}), 2);
        chk_i("t1_busy_len", blen[bb], 4);
        chk_i("t1_resp_cyc", rc, c0 + 5);
        chk_l("t1_rdata", di, pattern(32'h40));
        chk_i("t1_resps", rq.size() - rb, 1);
        chk_i("t1_resp_src", int'(rq[rb].is_d), 0);

        // dcache writeback
        lat = 3; gb = gq.size(); rb = rq.size();
        wd = {8{32'hDEADBEEF}};
        d_txn(32'h0000_1000, 1'b0, 1'b1, wd, dd, rc);
        ref_mem[32'h1000] = wd;
        repeat (2) @(negedge clk);
        chk_i("t2_is_write", int'({gq[gb].rd, gq[gb].wr}), 1);
        chk_i("t2_mem_addr", int'(gq[gb].addr), 32'h1000);
        chk_l("t2_mem_wdata", gq[gb].wdata, wd);
        chk_i("t2_resp_lat", rc - gq[gb].cyc, lat);
        chk_i("t2_resp_src", int'(rq[rb].is_d), 1);
        d_txn(32'h0000_1000, 1'b1, 1'b0, '0, dd, rc);
        chk_l("t2_readback", dd, wd);

        // Simultaneous requests after reset: D first, I right behind
        do_reset();
        rb = rq.size();
        fork
            i_txn(32'h0000_0080, di, ri);
            d_txn(32'h0000_2000, 1'b1, 1'b0, '0, dd, rd);
        join
        repeat (2) @(negedge clk);
        chk_i("t3_first_d", int'(rq[rb].is_d), 1);
        chk_i("t3_second_i", int'(rq[rb+1].is_d), 0);
        chk_i("t3_gap", ri - rd, lat + 2);
        chk_l("t3_i_data", di, pattern(32'h80));
        chk_l("t3_d_data", dd, pattern(32'h2000));

        // Continuous re-requests: strict alternation D,I,D,I,D,I
        lat = 2; rb = rq.size();
        fork
            begin
                logic [255:0] x;
                int r;
                for (int k = 0; k < 3; k++) begin
                    i_txn(32'h0000_0100 + 32'(k) * 32'h20, x, r);
                    chk_l("t4_i_data", x, pattern(32'h0000_0100 + 32'(k) * 32'h20));
                end
            end
            begin
                logic [255:0] y;
                int r2;
                for (int k = 0; k < 3; k++) begin
                    d_txn(32'h0000_3000 + 32'(k) * 32'h20, 1'b1, 1'b0, '0, y, r2);
                    chk_l("t4_d_data", y, pattern(32'h0000_3000 + 32'(k) * 32'h20));
                end
            end
        join
        repeat (2) @(negedge clk);
        chk_i("t4_resps", rq.size() - rb, 6);
        for (int k = 0; k < 6; k++)
            if (rb + k < rq.size())
                chk_i("t4_order", int'(rq[rb+k].is_d), (k % 2 == 0) ? 1 : 0);

        // Reset one cycle into GNT_I
        lat = 6; rb = rq.size();
        bus.i_addr = 32'h0000_0300;
        bus.i_read = 1'b1;
        @(negedge clk);
        chk_i("t5_granted", int'(bus.mem_read), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk_i("t5_async_mem_read", int'(bus.mem_read), 0);
        chk_i("t5_async_mem_addr", int'(bus.mem_addr), 0);
        bus.i_read = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_i("t5_no_resp", rq.size() - rb, 0);
        lat = 2;
        i_txn(32'h0000_0340, di, rc);
        chk_i("t5_fresh_done", int'(rc >= 0), 1);
        chk_l("t5_fresh_data", di, pattern(32'h340));

        // Spurious mem_resp while idle
        repeat (2) @(negedge clk);
        gb = gq.size(); rb = rq.size();
        #1 spurious = 1'b1;
        @(negedge clk);
        #1 spurious = 1'b0;
        repeat (3) @(negedge clk);
        chk_i("t6_no_resp", rq.size() - rb, 0);
        chk_i("t6_no_grant", gq.size() - gb, 0);

        // d_read and d_write together: issued as a write
        gb = gq.size();
        wd = rnd_line();
        d_txn(32'h0000_5000, 1'b1, 1'b1, wd, dd, rc);
        ref_mem[32'h5000] = wd;
        repeat (2) @(negedge clk);
        chk_i("t6_rw_is_write", int'({gq[gb].rd, gq[gb].wr}), 1);
        chk_l("t6_rw_wdata", gq[gb].wdata, wd);
        d_txn(32'h0000_5000, 1'b1, 1'b0, '0, dd, rc);
        chk_l("t6_rw_readback", dd, wd);

        // Randomised concurrent traffic on disjoint address pools
        for (int b = 0; b < 3; b++) begin
            lat = $urandom_range(1, 5);
            gb = gq.size();
            fork
                begin
                    logic [31:0] a;
                    logic [255:0] x;
                    int r;
                    for (int n = 0; n < 8; n++) begin
                        a = 32'h0000_8000 + 32'($urandom_range(0, 7)) * 32'h20;
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                        i_txn(a, x, r);
                        chk_i("rnd_i_done", int'(r >= 0), 1);
                        chk_l("rnd_i_data", x, pattern(a));
                    end
                end
                begin
                    logic [31:0] a2;
                    logic [255:0] y, w;
                    int r2;
                    bit isw;
                    for (int n = 0; n < 8; n++) begin
                        a2 = 32'h0000_C000 + 32'($urandom_range(0, 7)) * 32'h20;
                        isw = $urandom_range(0, 1) == 1;
                        w = rnd_line();
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                        d_txn(a2, !isw, isw, w, y, r2);
                        chk_i("rnd_d_done", int'(r2 >= 0), 1);
                        if (isw) ref_mem[a2] = w;
                        else chk_l("rnd_d_data", y, ref_mem.exists(a2) ? ref_mem[a2] : pattern(a2));
                    end
                end
            join
            repeat (2) @(negedge clk);
            chk_i("rnd_grants", gq.size() - gb, 16);
        end

        chk_i("resp_single_cycle", wide_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
